key_entry_ctrl: RTL and testbench

KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

---
 rtl/key_entry_ctrl.sv | 108 ++++++++++
 tb/tb_key_entry_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: keypad BCD entry FSM that decodes keys, edits the buffer and commits the value.
// Optional idle timeout is enabled by defining KEY_TIMEOUT_EN.
module key_entry_ctrl #(
   parameter int MAX_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_strobe,
   input  logic [7:0]  key_code,
   output logic [15:0] entry_buf,
   output logic [2:0]  digit_cnt,
   output logic        entry_active,
   output logic [15:0] value_bcd,
   output logic [13:0] value_bin,
   output logic        value_valid,
   output logic        key_err
);
   typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;
   localparam logic [2:0] MAXD = 3'(MAX_DIGITS);
   state_t state;
   logic [1:0] row_idx, col_idx;
   logic [3:0] idx;
   logic valid, is_digit, timeout;
   logic [13:0] bin;
   always_comb begin
      row_idx = '0;
      col_idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (!key_code[i+4]) row_idx = 2'(i);
         if (!key_code[i]) col_idx = 2'(i);
      end
   end
   assign valid    = $onehot(~key_code[7:4]) && $onehot(~key_code[3:0]);
   assign idx      = {row_idx, col_idx};
   assign is_digit = idx < 4'd10;
   assign bin = 14'(entry_buf[15:12]) * 14'd1000 + 14'(entry_buf[11:8]) * 14'd100
              + 14'(entry_buf[7:4]) * 14'd10 + 14'(entry_buf[3:0]);
`ifdef KEY_TIMEOUT_EN
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tmo_cnt;
   assign timeout = state == ENTRY && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
   // Any well-formed key restarts the idle interval, including ignored keys.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_cnt <= '0;
      else tmo_cnt <= (state != ENTRY || (key_strobe && valid) || timeout) ? '0 : tmo_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         entry_buf    <= '0;
         digit_cnt    <= '0;
         entry_active <= 1'b0;
         value_bcd    <= '0;
         value_bin    <= '0;
         value_valid  <= 1'b0;
         key_err      <= 1'b0;
      end else begin
         value_valid <= 1'b0;
         key_err     <= 1'b0;
         case (state)
            IDLE: begin
               if (key_strobe && !valid) key_err <= 1'b1;
               else if (key_strobe && is_digit) begin
                  entry_buf    <= {12'h0, idx};
                  digit_cnt    <= 3'd1;
                  entry_active <= 1'b1;
                  state        <= ENTRY;
               end
            end
            ENTRY: begin
               if (key_strobe && !valid) key_err <= 1'b1;
               else if (key_strobe && is_digit) begin
                  if (digit_cnt < MAXD) begin
                     entry_buf <= {entry_buf[11:0], idx};
                     digit_cnt <= digit_cnt + 3'd1;
                  end else key_err <= 1'b1;
               end else if (key_strobe && idx == 4'd10) begin
                  value_bcd    <= entry_buf;
                  value_bin    <= bin;
                  value_valid  <= 1'b1;
                  entry_buf    <= '0;
                  digit_cnt    <= '0;
                  entry_active <= 1'b0;
                  state        <= COMMIT;
               end else if (key_strobe && idx == 4'd12) begin
                  entry_buf <= {4'h0, entry_buf[15:4]};
                  digit_cnt <= digit_cnt - 3'd1;
                  if (digit_cnt == 3'd1) begin
                     entry_active <= 1'b0;
                     state        <= IDLE;
                  end
               end else if ((key_strobe && idx == 4'd11) || (!key_strobe && timeout)) begin
                  key_err      <= !key_strobe;
                  entry_buf    <= '0;
                  digit_cnt    <= '0;
                  entry_active <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb_key_entry_ctrl: table-driven directed checks of key_entry_ctrl plus reset and timeout sequences.
module tb_key_entry_ctrl;
   logic clk = 1'b0, rst = 1'b1, key_strobe = 1'b0;
   logic [7:0] key_code = 8'hFF;
   logic [15:0] entry_buf, value_bcd;
   logic [2:0] digit_cnt;
   logic entry_active, value_valid, key_err;
   logic [13:0] value_bin;
   int n_vec = 0, n_bad = 0;

   typedef struct {
      logic       s;
      logic [7:0] code;
      logic [51:0] exp;
   } vec_t;
   vec_t vq[$];

   key_entry_ctrl #(.MAX_DIGITS(4), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .key_strobe(key_strobe), .key_code(key_code),
      .entry_buf(entry_buf), .digit_cnt(digit_cnt), .entry_active(entry_active),
      .value_bcd(value_bcd), .value_bin(value_bin), .value_valid(value_valid), .key_err(key_err)
   );

   always #5 clk = ~clk;

   function automatic logic [51:0] e(logic [15:0] b, logic [2:0] c, logic a, logic [15:0] bcd,
                                     logic [13:0] bn, logic vv, logic er);
      return {b, c, a, bcd, bn, vv, er};
   endfunction

   function automatic logic [51:0] outs();
      return {entry_buf, digit_cnt, entry_active, value_bcd, value_bin, value_valid, key_err};
   endfunction

   task automatic check(string name, logic [51:0] exp);
      logic [51:0] got;
      got = outs();
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got buf=%h cnt=%0d act=%b bcd=%h bin=%0d vv=%b err=%b, want buf=%h cnt=%0d act=%b bcd=%h bin=%0d vv=%b err=%b",
                  name, got[51:36], got[35:33], got[32], got[31:16], got[15:2], got[1], got[0],
                  exp[51:36], exp[35:33], exp[32], exp[31:16], exp[15:2], exp[1], exp[0]);
      end
   endtask

   task automatic apply(logic s, logic [7:0] c);
      key_strobe = s;
      key_code   = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Sequence: 1234 commit, overflow, invalid/ignored/clear, backspace to idle, 907 commit, 0 commit.
      vq.push_back('{1'b1, 8'hED, e(16'h0001, 3'd1, 1'b1, 16'h0000, 14'd0, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hEB, e(16'h0012, 3'd2, 1'b1, 16'h0000, 14'd0, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hE7, e(16'h0123, 3'd3, 1'b1, 16'h0000, 14'd0, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hDE, e(16'h1234, 3'd4, 1'b1, 16'h0000, 14'd0, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hBB, e(16'h0000, 3'd0, 1'b0, 16'h1234, 14'd1234, 1'b1, 1'b0)});
      vq.push_back('{1'b1, 8'hED, e(16'h0000, 3'd0, 1'b0, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hED, e(16'h0001, 3'd1, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hEB, e(16'h0012, 3'd2, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hE7, e(16'h0123, 3'd3, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hDE, e(16'h1234, 3'd4, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hDD, e(16'h1234, 3'd4, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b1)});
      vq.push_back('{1'b0, 8'hFF, e(16'h1234, 3'd4, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hCE, e(16'h1234, 3'd4, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b1)});
      vq.push_back('{1'b1, 8'h7D, e(16'h1234, 3'd4, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hB7, e(16'h0000, 3'd0, 1'b0, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hED, e(16'h0001, 3'd1, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hEB, e(16'h0012, 3'd2, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'h7E, e(16'h0001, 3'd1, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'h7E, e(16'h0000, 3'd0, 1'b0, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hBB, e(16'h0000, 3'd0, 1'b0, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'h7E, e(16'h0000, 3'd0, 1'b0, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hCE, e(16'h0000, 3'd0, 1'b0, 16'h1234, 14'd1234, 1'b0, 1'b1)});
      vq.push_back('{1'b1, 8'hBD, e(16'h0009, 3'd1, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hEE, e(16'h0090, 3'd2, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hD7, e(16'h0907, 3'd3, 1'b1, 16'h1234, 14'd1234, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hBB, e(16'h0000, 3'd0, 1'b0, 16'h0907, 14'd907, 1'b1, 1'b0)});
      vq.push_back('{1'b0, 8'hFF, e(16'h0000, 3'd0, 1'b0, 16'h0907, 14'd907, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hEE, e(16'h0000, 3'd1, 1'b1, 16'h0907, 14'd907, 1'b0, 1'b0)});
      vq.push_back('{1'b1, 8'hBB, e(16'h0000, 3'd0, 1'b0, 16'h0000, 14'd0, 1'b1, 1'b0)});
      vq.push_back('{1'b0, 8'hFF, e(16'h0000, 3'd0, 1'b0, 16'h0000, 14'd0, 1'b0, 1'b0)});

      repeat (2) @(posedge clk);
      #1;
      check("reset", e(16'h0, 3'd0, 1'b0, 16'h0, 14'd0, 1'b0, 1'b0));
      rst = 1'b0;
      foreach (vq[i]) begin
         apply(vq[i].s, vq[i].code);
         check($sformatf("vec%0d", i), vq[i].exp);
      end

`ifdef KEY_TIMEOUT_EN
      apply(1'b1, 8'hE7);
      check("tmo_start", e(16'h0003, 3'd1, 1'b1, 16'h0, 14'd0, 1'b0, 1'b0));
      repeat (99) apply(1'b0, 8'hFF);
      check("tmo_before", e(16'h0003, 3'd1, 1'b1, 16'h0, 14'd0, 1'b0, 1'b0));
      apply(1'b0, 8'hFF);
      check("tmo_fire", e(16'h0000, 3'd0, 1'b0, 16'h0, 14'd0, 1'b0, 1'b1));
      apply(1'b0, 8'hFF);
      check("tmo_after", e(16'h0000, 3'd0, 1'b0, 16'h0, 14'd0, 1'b0, 1'b0));
`else
      apply(1'b1, 8'hE7);
      check("persist_start", e(16'h0003, 3'd1, 1'b1, 16'h0, 14'd0, 1'b0, 1'b0));
      repeat (200) apply(1'b0, 8'hFF);
      check("persist_hold", e(16'h0003, 3'd1, 1'b1, 16'h0, 14'd0, 1'b0, 1'b0));
      apply(1'b1, 8'hB7);
      check("persist_clear", e(16'h0000, 3'd0, 1'b0, 16'h0, 14'd0, 1'b0, 1'b0));
`endif

      apply(1'b1, 8'hBD);
      apply(1'b1, 8'hBD);
      check("pre_rst", e(16'h0099, 3'd2, 1'b1, 16'h0, 14'd0, 1'b0, 1'b0));
      key_strobe = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_rst", e(16'h0, 3'd0, 1'b0, 16'h0, 14'd0, 1'b0, 1'b0));
      @(posedge clk);
      #1 rst = 1'b0;
      apply(1'b1, 8'hBB);
      check("enter_after_rst", e(16'h0, 3'd0, 1'b0, 16'h0, 14'd0, 1'b0, 1'b0));
      apply(1'b0, 8'hFF);
      check("idle_after_rst", e(16'h0, 3'd0, 1'b0, 16'h0, 14'd0, 1'b0, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
